ascon_enc_sched: RTL and testbench

Two-requester scheduler for the single-block Ascon-128a encryption core (`encrypt_1block_128a`). It arbitrates round-robin between two operand sources and latches the winner's key, nonce, associated data and plaintext. It then sequences the core (reset pulse, fixed-latency run) and returns ciphertext and tag, tagged with the requester ID, over a valid/ready result port. It sits between the system-side request logic and the core, replacing free-running input/output registering with an explicit handshake.

---
 rtl/ascon_sched_pkg.sv | 6 +
 rtl/ascon_enc_sched_rr_arb2.sv | 13 +
 rtl/ascon_enc_sched.sv | 99 +++++++++
 tb/tb_ascon_enc_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ascon_sched_pkg.sv
// ascon_sched_pkg: shared types and widths for the Ascon-128a encryption scheduler
package ascon_sched_pkg;
    localparam int ASCON_W = 128;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    typedef logic req_id_t;
endpackage

// File: rtl/ascon_enc_sched_rr_arb2.sv
// rr_arb2: two-way round-robin grant; a tie goes to the requester not granted last
module rr_arb2
    import ascon_sched_pkg::*;
(
    input  logic    v0,
    input  logic    v1,
    input  req_id_t last,
    output logic    g0,
    output logic    g1
);
    assign g0 = v0 & (~v1 | last);
    assign g1 = v1 & (~v0 | ~last);
endmodule

// File: rtl/ascon_enc_sched.sv
// ascon_enc_sched: arbitrates two requesters onto one Ascon-128a core and returns tagged results
module ascon_enc_sched
    import ascon_sched_pkg::*;
#(
    parameter int CORE_LAT = 12,
    parameter int CNT_W    = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               rq0_valid,
    output logic               rq0_ready,
    input  logic [ASCON_W-1:0] rq0_sk,
    input  logic [ASCON_W-1:0] rq0_n,
    input  logic [ASCON_W-1:0] rq0_a,
    input  logic [ASCON_W-1:0] rq0_p,
    input  logic               rq1_valid,
    output logic               rq1_ready,
    input  logic [ASCON_W-1:0] rq1_sk,
    input  logic [ASCON_W-1:0] rq1_n,
    input  logic [ASCON_W-1:0] rq1_a,
    input  logic [ASCON_W-1:0] rq1_p,
    output logic [ASCON_W-1:0] core_sk,
    output logic [ASCON_W-1:0] core_n,
    output logic [ASCON_W-1:0] core_a,
    output logic [ASCON_W-1:0] core_p,
    output logic               core_rst,
    input  logic [ASCON_W-1:0] core_c,
    input  logic [ASCON_W-1:0] core_t,
    output logic               res_valid,
    input  logic               res_ready,
    output req_id_t            res_id,
    output logic [ASCON_W-1:0] res_c,
    output logic [ASCON_W-1:0] res_t
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CORE_LAT - 1);

    state_t           state;
    req_id_t          last;
    logic [CNT_W-1:0] cnt;
    logic             g0, g1;

    rr_arb2 u_arb (
        .v0   (rq0_valid),
        .v1   (rq1_valid),
        .last (last),
        .g0   (g0),
        .g1   (g1)
    );

    assign rq0_ready = g0 & (state == IDLE) & ~RST;
    assign rq1_ready = g1 & (state == IDLE) & ~RST;
    assign core_rst  = RST | (state == LOAD);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            last      <= 1'b1;
            cnt       <= '0;
            core_sk   <= '0;
            core_n    <= '0;
            core_a    <= '0;
            core_p    <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_c     <= '0;
            res_t     <= '0;
        end else begin
            case (state)
                IDLE: if (rq0_ready | rq1_ready) begin
                    core_sk <= g1 ? rq1_sk : rq0_sk;
                    core_n  <= g1 ? rq1_n  : rq0_n;
                    core_a  <= g1 ? rq1_a  : rq0_a;
                    core_p  <= g1 ? rq1_p  : rq0_p;
                    res_id  <= g1;
                    last    <= g1;
                    state   <= LOAD;
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        res_c     <= core_c;
                        res_t     <= core_t;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_enc_sched.sv
// tb_ascon_enc_sched: vector table, corner sequences and random round-robin traffic against a transaction model
module tb_ascon_enc_sched;
    localparam int CORE_LAT = 12;
    localparam logic [127:0] K = 128'h000102030405060708090A0B0C0D0E0F;

    logic CLK = 0, RST = 1;
    logic rq0_valid = 0, rq1_valid = 0, res_ready = 0;
    logic [127:0] rq0_sk, rq0_n, rq0_a, rq0_p, rq1_sk, rq1_n, rq1_a, rq1_p;
    logic [127:0] core_sk, core_n, core_a, core_p, core_c, core_t, res_c, res_t;
    logic rq0_ready, rq1_ready, core_rst, res_valid, res_id;
    int n_cmp = 0, n_bad = 0, ccnt = 0;

    always #5 CLK = ~CLK;

    ascon_enc_sched #(.CORE_LAT(CORE_LAT), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready),
        .rq0_sk(rq0_sk), .rq0_n(rq0_n), .rq0_a(rq0_a), .rq0_p(rq0_p),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready),
        .rq1_sk(rq1_sk), .rq1_n(rq1_n), .rq1_a(rq1_a), .rq1_p(rq1_p),
        .core_sk(core_sk), .core_n(core_n), .core_a(core_a), .core_p(core_p),
        .core_rst(core_rst), .core_c(core_c), .core_t(core_t),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_c(res_c), .res_t(res_t)
    );

    function automatic logic [127:0] fc(input logic [127:0] k, n, p);
        return k ^ p ^ {n[63:0], n[127:64]};
    endfunction
    function automatic logic [127:0] ft(input logic [127:0] k, n, a, p);
        return k + n + a + p;
    endfunction
    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in core: outputs are garbage until CORE_LAT cycles after reset release
    always_ff @(posedge CLK) ccnt <= core_rst ? 0 : ccnt + 1;
    assign core_c = (ccnt >= CORE_LAT - 1) ? fc(core_sk, core_n, core_p) : ~fc(core_sk, core_n, core_p);
    assign core_t = (ccnt >= CORE_LAT - 1) ? ft(core_sk, core_n, core_a, core_p) : 128'hBAD;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic scramble;
        rq0_sk = rnd(); rq0_n = rnd(); rq0_a = rnd(); rq0_p = rnd();
        rq1_sk = rnd(); rq1_n = rnd(); rq1_a = rnd(); rq1_p = rnd();
    endtask

    task automatic wait_grant(output bit ok);
        int n = 0;
        #1;
        while (!(rq0_ready | rq1_ready) && n < 40) begin
            tick;
            n++;
        end
        ok = rq0_ready | rq1_ready;
        check("grant_timeout", {255'd0, ok}, 256'd1);
    endtask

    task automatic run_txn(input bit v0, input bit v1, input bit exp_id, input int bp, input bit fixed, output bit got);
        logic [127:0] e_sk, e_n, e_a, e_p, ec, et;
        bit ok;
        scramble();
        if (fixed) begin
            rq0_sk = K; rq0_n = K; rq0_a = K; rq0_p = K;
        end
        {e_sk, e_n, e_a, e_p} = exp_id ? {rq1_sk, rq1_n, rq1_a, rq1_p} : {rq0_sk, rq0_n, rq0_a, rq0_p};
        ec = fc(e_sk, e_n, e_p);
        et = ft(e_sk, e_n, e_a, e_p);
        rq0_valid = v0;
        rq1_valid = v1;
        got = exp_id;
        wait_grant(ok);
        if (!ok) begin
            rq0_valid = 0;
            rq1_valid = 0;
            return;
        end
        got = rq1_ready;
        check("ready_onehot", {254'd0, rq1_ready, rq0_ready}, exp_id ? 256'd2 : 256'd1);
        tick;
        rq0_valid = 0;
        rq1_valid = 0;
        scramble();
        @(negedge CLK);
        check("load_core_rst", {254'd0, core_rst, res_valid}, 256'd2);
        check("load_ops_sk_n", {core_sk, core_n}, {e_sk, e_n});
        check("load_ops_a_p", {core_a, core_p}, {e_a, e_p});
        for (int k = 0; k < CORE_LAT; k++) begin
            tick;
            @(negedge CLK);
            check("run_flags", {254'd0, core_rst, res_valid}, 256'd0);
        end
        tick;
        @(negedge CLK);
        check("res_valid", {255'd0, res_valid}, 256'd1);
        check("res_id", {255'd0, res_id}, {255'd0, exp_id});
        check("res_c_t", {res_c, res_t}, {ec, et});
        for (int i = 0; i < bp; i++) begin
            tick;
            rq0_valid = 1;
            rq1_valid = 1;
            #1;
            check("bp_flags", {252'd0, res_valid, rq0_ready, rq1_ready, res_id}, {252'd0, 3'b100, exp_id});
            check("bp_data", {res_c, res_t}, {ec, et});
        end
        check("hold_ops", {core_sk ^ core_n, core_a ^ core_p}, {e_sk ^ e_n, e_a ^ e_p});
        @(negedge CLK);
        rq0_valid = 0;
        rq1_valid = 0;
        res_ready = 1;
        tick;
        res_ready = 0;
        @(negedge CLK);
        check("handoff", {255'd0, res_valid}, 256'd0);
    endtask

    typedef struct packed {
        bit v0;
        bit v1;
        bit id;
        bit fixed;
        int bp;
    } vec_t;
    vec_t tbl [10];

    initial begin
        bit got, ok, last;
        int skips, seen;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 20};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 2};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 3};
        scramble();
        rq0_valid = 1;
        rq1_valid = 1;
        tick;
        tick;
        @(negedge CLK);
        check("rst_flags", {252'd0, rq0_ready, rq1_ready, core_rst, res_valid}, 256'd2);
        check("rst_res", {res_c, res_t}, 256'd0);
        check("rst_core", {core_sk | core_n, core_a | core_p}, 256'd0);
        check("rst_id", {255'd0, res_id}, 256'd0);
        RST = 0;
        rq0_valid = 0;
        rq1_valid = 0;
        for (int i = 0; i < 10; i++)
            run_txn(tbl[i].v0, tbl[i].v1, tbl[i].id, tbl[i].bp, tbl[i].fixed, got);

        // Reset in the middle of a run discards the result and restores the tie preference
        scramble();
        rq0_valid = 1;
        wait_grant(ok);
        tick;
        rq0_valid = 0;
        repeat (5) tick;
        RST = 1;
        rq0_valid = 1;
        rq1_valid = 1;
        #1;
        check("mid_rst_flags", {253'd0, core_rst, rq0_ready, rq1_ready}, 256'd4);
        @(negedge CLK);
        rq0_valid = 0;
        rq1_valid = 0;
        tick;
        RST = 0;
        @(negedge CLK);
        check("post_rst_flags", {254'd0, core_rst, res_valid}, 256'd0);
        check("post_rst_data", {res_c | core_sk, res_t | core_p}, 256'd0);
        seen = 0;
        repeat (20) begin
            tick;
            seen += int'(res_valid);
        end
        check("no_stale_result", 256'(seen), 256'd0);
        run_txn(1, 1, 0, 0, 0, got);

        // Random traffic: requester 1 always or often valid, requester 0 bursty
        last = 0;
        skips = 0;
        for (int i = 0; i < 30; i++) begin
            bit v0, v1, e;
            v1 = (i < 15) ? 1'b1 : 1'($urandom_range(0, 1));
            v0 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v1 = 1;
            e = (v0 && v1) ? ~last : v1;
            run_txn(v0, v1, e, $urandom_range(0, 3), 0, got);
            last = e;
            skips = (v1 && !got) ? skips + 1 : 0;
            if (v1) check("rq1_not_starved", 256'(skips > 1), 256'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
